ex_issue_stage: RTL and testbench
=================================

Name: ex_issue_stage

Overview:
- ID/EX pipeline register for the 5-stage RISC-V core.
- Captures decoded operands and control from ID each clock and translates ALUOp/funct3/funct7 into the 4-bit ALU Operation code.
- Applies EX/MEM and MEM/WB forwarding to produce SrcA/SrcB for the EX-stage ALU.
- Detects load-use hazards and raises a stall request to the front end.

Parameters:
- DATA_WIDTH, 32, operand/data width
- REG_ADDR_WIDTH, 5, register index width
- OPCODE_LENGTH, 4, ALU Operation code width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous active-high reset
- stall  in  1  hold ID/EX contents
- flush  in  1  insert bubble into ID/EX
- id_valid  in  1  ID holds a real instruction
- id_rs1_data, id_rs2_data  in  DATA_WIDTH  register-file read data
- id_imm  in  DATA_WIDTH  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  REG_ADDR_WIDTH  register indices
- id_alu_src  in  1  1 = SrcB from immediate
- id_alu_op  in  2  00 mem, 01 branch, 10 arith/logic, 11 reserved
- id_funct3  in  3  instruction funct3
- id_funct7_b5  in  1  instruction bit 30
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- mem_reg_write  in  1  EX/MEM writes a register
- mem_rd  in  REG_ADDR_WIDTH  EX/MEM destination
- mem_alu_result  in  DATA_WIDTH  EX/MEM forward value
- wb_reg_write  in  1  MEM/WB writes a register
- wb_rd  in  REG_ADDR_WIDTH  MEM/WB destination
- wb_data  in  DATA_WIDTH  MEM/WB forward value
- SrcA, SrcB  out  DATA_WIDTH  ALU operands
- Operation  out  OPCODE_LENGTH  ALU operation (registered)
- ex_store_data  out  DATA_WIDTH  forwarded rs2 value for stores
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control
- ex_rd  out  REG_ADDR_WIDTH  registered destination
- hazard_stall  out  1  load-use stall request to PC/IF/ID

Behaviour:
- Register update on rising clk. Priority: reset > flush > stall > load.
- Reset: all ID/EX state cleared to 0, Operation = 4'b0000. Outputs read 0 except where forwarding supplies a value.
- Flush: ex_valid, ex_reg_write, ex_mem_read and ex_mem_write go to 0. Data, rd and Operation fields go to 0.
- Stall without flush: all state holds.
- Load: capture all id_* fields. ex_valid = id_valid. Each control bit is ANDed with id_valid.
- Latency: 1 cycle from ID inputs to registered outputs. Forwarding muxes are combinational on registered state and current mem_*/wb_* inputs.
- Operation decode (registered):
  - alu_op 00: ADD 0010.
  - alu_op 01: funct3 000 → EQ 1000; 001 → BNE 0011; else 1111.
  - alu_op 10: funct3 000 → SUB 0001 if alu_src=0 and funct7_b5=1, else ADD 0010; 111 → AND 0000; 110 → OR 0100; else 1111.
  - alu_op 11: 1111.
  - The ALU returns 0 for 1111.
- Forwarding for operand A (rs1); the rs2 path is identical:
  - EX/MEM hit when mem_reg_write=1, mem_rd≠0 and mem_rd=ex_rs1 → mem_alu_result.
  - Otherwise MEM/WB hit when wb_reg_write=1, wb_rd≠0 and wb_rd=ex_rs1 → wb_data.
  - Otherwise the registered read data.
  - EX/MEM beats MEM/WB when both match.
  - x0 is never forwarded.
  - Forwarding is active only while ex_valid=1; a bubble uses registered values.
- SrcA = forwarded rs1. SrcB = registered imm if alu_src=1, else forwarded rs2. ex_store_data is always forwarded rs2.
- hazard_stall = ex_valid & ex_mem_read & ex_rd≠0 & (ex_rd=id_rs1 | ex_rd=id_rs2). Combinational.
- The external controller answers hazard_stall with stall on IF/ID and flush on this block in the same cycle. This block does not self-flush.
- Reset mid-stall: reset wins and clears state on that edge.

Test Plan:
- Reset: assert reset 2 cycles with id_* random → ex_valid=0, Operation=0000, SrcA=SrcB=0, hazard_stall=0.
- Decode sweep: alu_op=10, funct3=000, alu_src=0, funct7_b5=1 → next cycle Operation=0001. Same with alu_src=1 → 0010. funct3=111 → 0000. funct3=110 → 0100. alu_op=01, funct3=001 → 0011. funct3=000 → 1000.
- Double forward: ex_rs1=5, mem_rd=5, wb_rd=5, both write enables set, mem_alu_result=0xAAAA0000, wb_data=0x12345678 → SrcA=0xAAAA0000. Drop mem_reg_write → SrcA=0x12345678.
- x0 guard: ex_rs2=0, mem_rd=0, mem_reg_write=1, mem_alu_result=0xFFFFFFFF, registered rs2 data=0, alu_src=0 → SrcB=0.
- Load-use: ex_mem_read=1, ex_rd=7, ex_valid=1, id_rs2=7 → hazard_stall=1. Same with ex_rd=0 → hazard_stall=0.
- Stall/flush priority: load ADD with rs1_data=3. Assert stall 3 cycles with new id_* → outputs unchanged. Assert stall and flush together → next cycle ex_valid=0, ex_reg_write=0, Operation=0000.

Source files
------------

// File: rtl/ex_issue_stage.sv
// ID/EX pipeline register: ALU op decode, EX/MEM + MEM/WB operand
// forwarding and load-use hazard detection for the 5-stage core.
module ex_issue_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int OPCODE_LENGTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [DATA_WIDTH-1:0]     id_rs1_data,
    input  logic [DATA_WIDTH-1:0]     id_rs2_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_alu_src,
    input  logic [1:0]                id_alu_op,
    input  logic [2:0]                id_funct3,
    input  logic                      id_funct7_b5,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      id_mem_write,
    input  logic                      mem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]     mem_alu_result,
    input  logic                      wb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    output logic [DATA_WIDTH-1:0]     SrcA,
    output logic [DATA_WIDTH-1:0]     SrcB,
    output logic [OPCODE_LENGTH-1:0]  Operation,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic                      ex_valid,
    output logic                      ex_reg_write,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      hazard_stall
);

    typedef logic [OPCODE_LENGTH-1:0] op_t;

    localparam op_t OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam op_t OP_SUB = OPCODE_LENGTH'(4'b0001);
    localparam op_t OP_ADD = OPCODE_LENGTH'(4'b0010);
    localparam op_t OP_BNE = OPCODE_LENGTH'(4'b0011);
    localparam op_t OP_OR  = OPCODE_LENGTH'(4'b0100);
    localparam op_t OP_EQ  = OPCODE_LENGTH'(4'b1000);
    localparam op_t OP_INV = OPCODE_LENGTH'(4'b1111);

    typedef struct packed {
        logic                      valid;
        logic                      reg_write;
        logic                      mem_read;
        logic                      mem_write;
        logic                      alu_src;
        logic [DATA_WIDTH-1:0]     rs1_data;
        logic [DATA_WIDTH-1:0]     rs2_data;
        logic [DATA_WIDTH-1:0]     imm;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
        op_t                       op;
    } id_ex_t;

    id_ex_t q;
    id_ex_t d;
    op_t    op_dec;

    always_comb begin
        op_dec = OP_INV;
        unique case (id_alu_op)
            2'b00: op_dec = OP_ADD;
            2'b01: begin
                unique case (1'b1)
                    (id_funct3 == 3'b000): op_dec = OP_EQ;
                    (id_funct3 == 3'b001): op_dec = OP_BNE;
                    default:               op_dec = OP_INV;
                endcase
            end
            2'b10: begin
                unique case (1'b1)
                    (id_funct3 == 3'b000):
                        op_dec = (!id_alu_src && id_funct7_b5) ? OP_SUB : OP_ADD;
                    (id_funct3 == 3'b111): op_dec = OP_AND;
                    (id_funct3 == 3'b110): op_dec = OP_OR;
                    default:               op_dec = OP_INV;
                endcase
            end
            default: op_dec = OP_INV;
        endcase
    end

    // Control bits are qualified by id_valid so a bubble never writes.
    always_comb begin
        d           = '0;
        d.valid     = id_valid;
        d.reg_write = id_reg_write & id_valid;
        d.mem_read  = id_mem_read & id_valid;
        d.mem_write = id_mem_write & id_valid;
        d.alu_src   = id_alu_src;
        d.rs1_data  = id_rs1_data;
        d.rs2_data  = id_rs2_data;
        d.imm       = id_imm;
        d.rs1       = id_rs1;
        d.rs2       = id_rs2;
        d.rd        = id_rd;
        d.op        = op_dec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!stall) begin
            q <= d;
        end
    end

    logic mem_hit_a;
    logic mem_hit_b;
    logic wb_hit_a;
    logic wb_hit_b;
    logic [DATA_WIDTH-1:0] fwd_a;
    logic [DATA_WIDTH-1:0] fwd_b;

    // EX/MEM is younger than MEM/WB, so it takes precedence.
    assign mem_hit_a = q.valid & mem_reg_write & (mem_rd != '0)
                       & (mem_rd == q.rs1);
    assign mem_hit_b = q.valid & mem_reg_write & (mem_rd != '0)
                       & (mem_rd == q.rs2);
    assign wb_hit_a  = q.valid & wb_reg_write & (wb_rd != '0)
                       & (wb_rd == q.rs1);
    assign wb_hit_b  = q.valid & wb_reg_write & (wb_rd != '0)
                       & (wb_rd == q.rs2);

    assign fwd_a = mem_hit_a ? mem_alu_result :
                   wb_hit_a  ? wb_data : q.rs1_data;
    assign fwd_b = mem_hit_b ? mem_alu_result :
                   wb_hit_b  ? wb_data : q.rs2_data;

    assign SrcA          = fwd_a;
    assign SrcB          = q.alu_src ? q.imm : fwd_b;
    assign ex_store_data = fwd_b;
    assign Operation     = q.op;
    assign ex_valid      = q.valid;
    assign ex_reg_write  = q.reg_write;
    assign ex_mem_read   = q.mem_read;
    assign ex_mem_write  = q.mem_write;
    assign ex_rd         = q.rd;

    assign hazard_stall = q.valid & q.mem_read & (q.rd != '0)
                          & ((q.rd == id_rs1) | (q.rd == id_rs2));

endmodule

// File: tb/tb_ex_issue_stage.sv
// Randomized self-checking bench for ex_issue_stage against a
// behavioural model of the ID/EX register and forwarding rules.
module tb_ex_issue_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_alu_src;
    logic [1:0]  id_alu_op;
    logic [2:0]  id_funct3;
    logic        id_funct7_b5, id_reg_write, id_mem_read, id_mem_write;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] SrcA, SrcB, ex_store_data;
    logic [3:0]  Operation;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]  ex_rd;
    logic        hazard_stall;

    always #5 clk = ~clk;

    ex_issue_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .id_funct3(id_funct3), .id_funct7_b5(id_funct7_b5),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .mem_reg_write(mem_reg_write),
        .mem_rd(mem_rd), .mem_alu_result(mem_alu_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .ex_store_data(ex_store_data), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_rd(ex_rd),
        .hazard_stall(hazard_stall)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model of the instruction currently sitting in EX.
    logic        m_valid, m_rw, m_mr, m_mw, m_src;
    logic [31:0] m_a, m_b, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [3:0]  m_op;

    function automatic logic [3:0] ref_op(input logic [1:0] aop,
        input logic [2:0] f3, input logic f7, input logic src);
        case (aop)
            2'd0: return 4'b0010;
            2'd1: return (f3 == 3'd0) ? 4'b1000 :
                         (f3 == 3'd1) ? 4'b0011 : 4'b1111;
            2'd2: case (f3)
                3'd0: return (!src && f7) ? 4'b0001 : 4'b0010;
                3'd7: return 4'b0000;
                3'd6: return 4'b0100;
                default: return 4'b1111;
            endcase
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] idx,
                                            input logic [31:0] regv);
        if (!m_valid || idx == 0) return regv;
        if (mem_reg_write && mem_rd == idx) return mem_alu_result;
        if (wb_reg_write && wb_rd == idx) return wb_data;
        return regv;
    endfunction

    task automatic model_clear();
        {m_valid, m_rw, m_mr, m_mw, m_src} = '0;
        {m_a, m_b, m_imm} = '0;
        {m_rs1, m_rs2, m_rd} = '0;
        m_op = 4'b0000;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset || flush) begin
            model_clear();
        end else if (!stall) begin
            m_valid = id_valid;
            m_rw  = id_valid && id_reg_write;
            m_mr  = id_valid && id_mem_read;
            m_mw  = id_valid && id_mem_write;
            m_src = id_alu_src;
            m_a = id_rs1_data; m_b = id_rs2_data; m_imm = id_imm;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
            m_op = ref_op(id_alu_op, id_funct3, id_funct7_b5, id_alu_src);
        end
        #1;
    endtask

    task automatic check_all();
        logic [31:0] fb;
        logic        hz;
        #1;
        fb = ref_fwd(m_rs2, m_b);
        hz = m_valid && m_mr && m_rd != 0 &&
             (m_rd == id_rs1 || m_rd == id_rs2);
        chk("srca", SrcA, ref_fwd(m_rs1, m_a));
        chk("srcb", SrcB, m_src ? m_imm : fb);
        chk("store", ex_store_data, fb);
        chk("op", 32'(Operation), 32'(m_op));
        chk("ctl", {28'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write},
            {28'd0, m_valid, m_rw, m_mr, m_mw});
        chk("rd", 32'(ex_rd), 32'(m_rd));
        chk("hazard", 32'(hazard_stall), 32'(hz));
    endtask

    task automatic rand_id();
        id_valid     = ($urandom_range(0, 7) != 0);
        id_rs1_data  = $urandom;
        id_rs2_data  = $urandom;
        id_imm       = $urandom;
        id_rs1       = 5'($urandom_range(0, 7));
        id_rs2       = 5'($urandom_range(0, 7));
        id_rd        = 5'($urandom_range(0, 7));
        id_alu_src   = 1'($urandom);
        id_alu_op    = 2'($urandom);
        id_funct3    = 3'($urandom);
        id_funct7_b5 = 1'($urandom);
        id_reg_write = 1'($urandom);
        id_mem_read  = 1'($urandom);
        id_mem_write = 1'($urandom);
    endtask

    task automatic rand_fwd();
        mem_reg_write  = 1'($urandom);
        mem_rd         = 5'($urandom_range(0, 7));
        mem_alu_result = $urandom;
        wb_reg_write   = 1'($urandom);
        wb_rd          = 5'($urandom_range(0, 7));
        wb_data        = $urandom;
    endtask

    task automatic load_id(input logic [1:0] aop, input logic [2:0] f3,
                           input logic f7, input logic src);
        rand_id();
        id_valid = 1'b1;
        id_alu_op = aop; id_funct3 = f3;
        id_funct7_b5 = f7; id_alu_src = src;
    endtask

    typedef struct {
        logic [1:0] aop;
        logic [2:0] f3;
        logic       f7;
        logic       src;
        logic [3:0] exp;
    } dec_vec_t;

    dec_vec_t dv[6];

    initial begin
        dv[0] = '{2'b10, 3'b000, 1'b1, 1'b0, 4'b0001};
        dv[1] = '{2'b10, 3'b000, 1'b1, 1'b1, 4'b0010};
        dv[2] = '{2'b10, 3'b111, 1'b0, 1'b0, 4'b0000};
        dv[3] = '{2'b10, 3'b110, 1'b0, 1'b0, 4'b0100};
        dv[4] = '{2'b01, 3'b001, 1'b0, 1'b0, 4'b0011};
        dv[5] = '{2'b01, 3'b000, 1'b0, 1'b0, 4'b1000};

        model_clear();
        stall = 0; flush = 0; reset = 1;
        rand_id();
        rand_fwd();
        #1;
        tick();
        rand_id();
        tick();
        mem_reg_write = 0; wb_reg_write = 0;
        #1;
        chk("rst_valid", 32'(ex_valid), 0);
        chk("rst_op", 32'(Operation), 0);
        chk("rst_srca", SrcA, 0);
        chk("rst_srcb", SrcB, 0);
        chk("rst_hz", 32'(hazard_stall), 0);
        reset = 0;

        foreach (dv[i]) begin
            load_id(dv[i].aop, dv[i].f3, dv[i].f7, dv[i].src);
            tick();
            chk($sformatf("dec%0d", i), 32'(Operation), 32'(dv[i].exp));
            check_all();
        end

        load_id(2'b10, 3'b000, 1'b0, 1'b0);
        id_rs1 = 5;
        tick();
        mem_reg_write = 1; mem_rd = 5; mem_alu_result = 32'hAAAA0000;
        wb_reg_write = 1; wb_rd = 5; wb_data = 32'h12345678;
        #1;
        chk("dfwd_mem", SrcA, 32'hAAAA0000);
        check_all();
        mem_reg_write = 0;
        #1;
        chk("dfwd_wb", SrcA, 32'h12345678);
        check_all();

        load_id(2'b10, 3'b000, 1'b0, 1'b0);
        id_rs2 = 0; id_rs2_data = 0;
        wb_reg_write = 0;
        tick();
        mem_reg_write = 1; mem_rd = 0; mem_alu_result = 32'hFFFFFFFF;
        #1;
        chk("x0_guard", SrcB, 0);
        check_all();

        load_id(2'b00, 3'b010, 1'b0, 1'b1);
        id_mem_read = 1; id_rd = 7;
        mem_reg_write = 0;
        tick();
        id_rs1 = 3; id_rs2 = 7;
        #1;
        chk("loaduse", 32'(hazard_stall), 1);
        check_all();
        load_id(2'b00, 3'b010, 1'b0, 1'b1);
        id_mem_read = 1; id_rd = 0;
        tick();
        id_rs1 = 0; id_rs2 = 0;
        #1;
        chk("loaduse_x0", 32'(hazard_stall), 0);
        check_all();

        load_id(2'b10, 3'b000, 1'b0, 1'b0);
        id_rs1 = 9; id_rs1_data = 3; id_reg_write = 1;
        tick();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            rand_id();
            tick();
            chk("stall_srca", SrcA, 3);
            chk("stall_op", 32'(Operation), 32'(4'b0010));
            chk("stall_valid", 32'(ex_valid), 1);
            check_all();
        end
        flush = 1;
        tick();
        chk("flush_valid", 32'(ex_valid), 0);
        chk("flush_rw", 32'(ex_reg_write), 0);
        chk("flush_op", 32'(Operation), 0);
        check_all();
        flush = 0;
        load_id(2'b01, 3'b001, 1'b0, 1'b0);
        stall = 0;
        tick();
        stall = 1; reset = 1;
        tick();
        chk("rst_stall", 32'(ex_valid), 0);
        check_all();
        reset = 0; stall = 0;

        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 31) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 5) == 0);
            rand_id();
            rand_fwd();
            check_all();
            tick();
        end
        reset = 0; flush = 0; stall = 0;
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
